// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
// DATA_W / ADDR_W : result width and register address width.
// wb_req_t        : one pending register write (destination + value).
// onehot_addr     : register address -> one-hot register mask.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NREGS-1:0] onehot_addr(input logic [ADDR_W-1:0] addr);
        logic [NREGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO, DEPTH entries of wb_req_t.
// Ports: clk, rst_n (async active-low), push/push_req, pop,
//        count (0..DEPTH), full, empty, head (oldest entry),
//        entry_addr (flat per-slot addresses), entry_valid (per-slot occupancy).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_req_t                 push_req,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output wb_req_t                 head,
    output logic [DEPTH*ADDR_W-1:0] entry_addr,
    output logic [DEPTH-1:0]        entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        entry_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr[i*ADDR_W +: ADDR_W] = mem[i].addr;
        end
    end

    // Storage carries no reset; entry_valid/count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    // Push and pop never target the same slot: that would need a full or
    // empty FIFO, and both cases are gated off above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results (unbuffered, priority) and
// load results (buffered in wb_fifo) share one registered write per cycle.
// Ports: clk, rst_n (async active-low);
//        alu_valid/alu_ready/alu_addr/alu_data  - ALU result handshake;
//        mem_valid/mem_ready/mem_addr/mem_data  - load result handshake;
//        rf_write/rf_addr/rf_data               - registered RF write port;
//        pending_mask                           - registers with writes in flight;
//        fifo_count                             - load FIFO occupancy.
module writeback_arbiter #(
    parameter int DATA_W       = wb_pkg::DATA_W,
    parameter int ADDR_W       = wb_pkg::ADDR_W,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     rf_write,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic [2**ADDR_W-1:0]     pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    import wb_pkg::*;

    localparam int ST_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t                 push_req;
    wb_req_t                 head;
    logic                    full;
    logic                    empty;
    logic [DEPTH*ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0]        entry_valid;
    logic [2**ADDR_W-1:0]    fifo_mask;
    logic                    alu_conflict;
    logic                    fifo_win;
    logic [ST_W-1:0]         starve_cnt;

    assign push_req = '{addr: mem_addr, data: mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (mem_valid && mem_ready),
        .push_req    (push_req),
        .pop         (fifo_win),
        .count       (fifo_count),
        .full        (full),
        .empty       (empty),
        .head        (head),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // An ALU write to a register still queued in the FIFO must wait, so the
    // queued (older) load lands first.
    always_comb begin
        alu_conflict = 1'b0;
        fifo_mask    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                if (entry_addr[i*ADDR_W +: ADDR_W] == alu_addr) begin
                    alu_conflict = 1'b1;
                end
                fifo_mask = fifo_mask | onehot_addr(entry_addr[i*ADDR_W +: ADDR_W]);
            end
        end
    end

    assign pending_mask = fifo_mask | (rf_write ? onehot_addr(rf_addr) : '0);
    assign fifo_win     = !empty && (!alu_valid || alu_conflict ||
                                     starve_cnt == ST_W'(STARVE_LIMIT));
    assign alu_ready    = !fifo_win;
    assign mem_ready    = !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write   <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            starve_cnt <= '0;
        end else begin
            if (fifo_win) begin
                rf_write <= 1'b1;
                rf_addr  <= head.addr;
                rf_data  <= head.data;
            end else if (alu_valid) begin
                rf_write <= 1'b1;
                rf_addr  <= alu_addr;
                rf_data  <= alu_data;
            end else begin
                rf_write <= 1'b0;
            end

            if (empty || fifo_win) begin
                starve_cnt <= '0;
            end else if (alu_valid && starve_cnt != ST_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + ST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a
// randomized run, checked against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic        rf_write;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic [15:0] pending_mask;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA_W       (16),
        .ADDR_W       (4),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .rf_write     (rf_write),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } req_t;

    req_t        q[$];
    int          starve;
    logic        m_w;
    logic [3:0]  m_a;
    logic [15:0] m_d;
    bit          m_alu_acc;
    bit          m_mem_acc;

    int tests_run = 0;
    int failures  = 0;

    logic [41:0] obs;
    logic [41:0] exp_v;
    assign obs = {alu_ready, mem_ready, rf_write, rf_addr, rf_data, pending_mask, fifo_count};

    function automatic bit m_fifo_win();
        bit hit = 1'b0;
        foreach (q[i]) if (q[i].a == alu_addr) hit = 1'b1;
        return (q.size() > 0) && (!alu_valid || hit || starve == LIMIT);
    endfunction

    function automatic logic [41:0] model_expect();
        logic [15:0] mask = '0;
        logic        mr;
        foreach (q[i]) mask[q[i].a] = 1'b1;
        if (m_w) mask[m_a] = 1'b1;
        mr = (q.size() < DEPTH);
        return {!m_fifo_win(), mr, m_w, m_a, m_d, mask, 3'(q.size())};
    endfunction

    task automatic model_reset();
        q.delete();
        starve    = 0;
        m_w       = 1'b0;
        m_a       = '0;
        m_d       = '0;
        m_alu_acc = 1'b0;
        m_mem_acc = 1'b0;
    endtask

    task automatic model_update();
        bit fw;
        bit was_empty;
        fw        = m_fifo_win();
        was_empty = (q.size() == 0);
        m_mem_acc = mem_valid && (q.size() < DEPTH);
        m_alu_acc = alu_valid && !fw;
        if (fw) begin
            m_w = 1'b1;
            m_a = q[0].a;
            m_d = q[0].d;
            void'(q.pop_front());
        end else if (alu_valid) begin
            m_w = 1'b1;
            m_a = alu_addr;
            m_d = alu_data;
        end else begin
            m_w = 1'b0;
        end
        if (was_empty || fw) starve = 0;
        else if (alu_valid && starve < LIMIT) starve++;
        if (m_mem_acc) q.push_back('{a: mem_addr, d: mem_data});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b1;
        alu_valid = 1'b1;
        alu_addr  = 4'd3;
        alu_data  = 16'h1234;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({rf_write, rf_addr, rf_data, fifo_count, pending_mask} !== '0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got w=%b a=%h d=%h cnt=%0d mask=%h required all zero",
                         k, rf_write, rf_addr, rf_data, fifo_count, pending_mask);
            end
            if (k < 2) tick();
        end
        rst_n = 1'b1;
        #1;
        exp_v = model_expect();
        tests_run++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_release: got %h required %h", obs, exp_v);
        end
        tick();
        tests_run++;
        if ({rf_write, rf_addr, rf_data, pending_mask} !== {1'b1, 4'd3, 16'h1234, 16'h0008}) begin
            failures++;
            $display("FAIL reset_first_alu: got w=%b a=%h d=%h mask=%h required w=1 a=3 d=1234 mask=0008",
                     rf_write, rf_addr, rf_data, pending_mask);
        end
        idle_inputs();
    endtask

    task automatic test_fifo_fill();
        int          ld = 0;
        bit          saw_full = 1'b0;
        logic [3:0]  order[$];
        for (int c = 0; c < 30 && !(ld == 5 && q.size() == 0); c++) begin
            alu_valid = (ld < 4);
            alu_addr  = 4'd8;
            alu_data  = 16'h8000 + 16'(c);
            mem_valid = (ld < 5);
            mem_addr  = (ld < 4) ? 4'(ld + 1) : 4'd10;
            mem_data  = 16'h1000 + 16'(ld);
            #1;
            exp_v = model_expect();
            tests_run++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL fill_cycle%0d: got %h required %h", c, obs, exp_v);
            end
            if (fifo_count == 3'd4 && !mem_ready && mem_valid) saw_full = 1'b1;
            tick();
            if (m_mem_acc) ld++;
            if (rf_write && rf_addr >= 4'd1 && rf_addr <= 4'd4) order.push_back(rf_addr);
        end
        idle_inputs();
        tests_run++;
        if (!saw_full) begin
            failures++;
            $display("FAIL fill_full: got no cycle with count=4 and mem_ready=0, required one");
        end
        tests_run++;
        if (order.size() != 4 || order[0] != 4'd1 || order[1] != 4'd2 ||
            order[2] != 4'd3 || order[3] != 4'd4) begin
            failures++;
            $display("FAIL fill_order: got %0d writes to R1..R4 (%p) required R1,R2,R3,R4", order.size(), order);
        end
        #1;
        tests_run++;
        if (fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL fill_drain: got count=%0d required 0", fifo_count);
        end
    endtask

    task automatic test_starvation();
        int wins = 0;
        bit forced = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 4'd6;
        alu_data  = 16'h0600;
        mem_valid = 1'b1;
        mem_addr  = 4'd5;
        mem_data  = 16'hAAAA;
        #1;
        tick();
        mem_valid = 1'b0;
        for (int c = 0; c < 10 && !forced; c++) begin
            alu_data = 16'h0601 + 16'(c);
            #1;
            exp_v = model_expect();
            tests_run++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL starve_cycle%0d: got %h required %h", c, obs, exp_v);
            end
            if (fifo_count != 0 && alu_ready) wins++;
            if (fifo_count != 0 && !alu_ready) forced = 1'b1;
            tick();
        end
        tests_run++;
        if (wins != 3 || !forced) begin
            failures++;
            $display("FAIL starve_wins: got %0d ALU wins (forced=%b) required 3 then forced", wins, forced);
        end
        tests_run++;
        if ({rf_write, rf_addr, rf_data} !== {1'b1, 4'd5, 16'hAAAA}) begin
            failures++;
            $display("FAIL starve_load: got w=%b a=%h d=%h required w=1 a=5 d=aaaa", rf_write, rf_addr, rf_data);
        end
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_resume: got alu_ready=%b required 1", alu_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_waw();
        logic [15:0] seen[$];
        bit          done = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 4'd9;
        alu_data  = 16'h0009;
        mem_valid = 1'b1;
        mem_addr  = 4'd7;
        mem_data  = 16'h0001;
        #1;
        tick();
        mem_valid = 1'b0;
        alu_addr  = 4'd7;
        alu_data  = 16'h0002;
        #1;
        tests_run++;
        if (alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL waw_stall: got alu_ready=%b required 0", alu_ready);
        end
        for (int c = 0; c < 10 && !done; c++) begin
            #1;
            exp_v = model_expect();
            tests_run++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL waw_cycle%0d: got %h required %h", c, obs, exp_v);
            end
            tick();
            if (rf_write && rf_addr == 4'd7) seen.push_back(rf_data);
            if (m_alu_acc) done = 1'b1;
        end
        idle_inputs();
        tests_run++;
        if (seen.size() != 2 || seen[0] != 16'h0001 || seen[1] != 16'h0002) begin
            failures++;
            $display("FAIL waw_order: got %0d R7 writes %p required 0001 then 0002", seen.size(), seen);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        alu_valid = 1'b1;
        alu_addr  = 4'd2;
        alu_data  = 16'h00FF;
        mem_valid = 1'b1;
        mem_addr  = 4'd2;
        mem_data  = 16'hFF00;
        #1;
        exp_v = model_expect();
        tests_run++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL same_present: got %h required %h", obs, exp_v);
        end
        tick();
        idle_inputs();
        #1;
        tests_run++;
        if ({rf_write, rf_addr, rf_data, pending_mask[2]} !== {1'b1, 4'd2, 16'h00FF, 1'b1}) begin
            failures++;
            $display("FAIL same_first: got w=%b a=%h d=%h m2=%b required w=1 a=2 d=00ff m2=1",
                     rf_write, rf_addr, rf_data, pending_mask[2]);
        end
        tick();
        tests_run++;
        if ({rf_write, rf_addr, rf_data, pending_mask[2]} !== {1'b1, 4'd2, 16'hFF00, 1'b1}) begin
            failures++;
            $display("FAIL same_second: got w=%b a=%h d=%h m2=%b required w=1 a=2 d=ff00 m2=1",
                     rf_write, rf_addr, rf_data, pending_mask[2]);
        end
        tick();
        tests_run++;
        if ({rf_write, pending_mask[2]} !== 2'b00) begin
            failures++;
            $display("FAIL same_clear: got w=%b m2=%b required w=0 m2=0", rf_write, pending_mask[2]);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'd8;
            alu_data  = 16'h0800 + 16'(c);
            mem_valid = 1'b1;
            mem_addr  = 4'(c + 1);
            mem_data  = 16'h0100 + 16'(c);
            tick();
        end
        idle_inputs();
        tests_run++;
        if ({rf_write, fifo_count} !== {1'b1, 3'd3}) begin
            failures++;
            $display("FAIL areset_setup: got w=%b cnt=%0d required w=1 cnt=3", rf_write, fifo_count);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rf_write, fifo_count, pending_mask} !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got w=%b cnt=%0d mask=%h required all zero",
                     rf_write, fifo_count, pending_mask);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_v = model_expect();
            tests_run++;
            if (obs !== exp_v || rf_write !== 1'b0) begin
                failures++;
                $display("FAIL areset_after%0d: got %h required %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_addr  = 4'($urandom_range(0, 3));
            alu_data  = 16'($urandom);
            mem_valid = 1'($urandom_range(0, 1));
            mem_addr  = 4'($urandom_range(0, 3));
            mem_data  = 16'($urandom);
            #1;
            exp_v = model_expect();
            tests_run++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h required %h", c, obs, exp_v);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fifo_fill();
        test_starvation();
        test_waw();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
